mod_sub_stream: RTL and testbench

Streaming modular subtractor for the Kyber datapath. It computes (A − B) mod q with q = 3329 over a 2-stage pipeline with valid/ready handshakes on both sides. It is the subtract-side companion of the combinational modular adder: inverse-NTT butterflies feed operand pairs in, and downstream stages drain results with backpressure. A per-result range-error flag and a saturating error counter support debug over the HPS bridge.

---
 rtl/mod_sub_stream_if.sv | 33 +++
 rtl/mod_sub_stream.sv | 77 +++++++
 tb/tb_mod_sub_stream.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_sub_stream_if.sv
// ---------------------------------------------------------------------------
// mod_sub_stream_if : operand/result stream bundle for mod_sub_stream
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mod_sub_stream_if #(
   parameter int W     = 16,
   parameter int TAG_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_a;
   logic [W-1:0]     in_b;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_d;
   logic [TAG_W-1:0] out_tag;
   logic             out_err;

   modport slave (
      input  in_valid, in_a, in_b, in_tag, out_ready,
      output in_ready, out_valid, out_d, out_tag, out_err
   );

   modport master (
      output in_valid, in_a, in_b, in_tag, out_ready,
      input  in_ready, out_valid, out_d, out_tag, out_err
   );
endinterface

`default_nettype wire

// File: rtl/mod_sub_stream.sv
// ---------------------------------------------------------------------------
// mod_sub_stream : 2-stage streaming (A - B) mod Q with range-error flagging
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mod_sub_stream #(
   parameter int Q     = 3329,
   parameter int W     = 16,
   parameter int TAG_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   mod_sub_stream_if.slave     io,
   output logic                busy,
   output logic [7:0]          err_count
);
   localparam logic [W-1:0] Q_W = W'(Q);

   logic             en;
   logic             in_err;

   logic             s1_valid;
   logic [W:0]       s1_d;
   logic             s1_err;
   logic [TAG_W-1:0] s1_tag;

   logic             s2_valid;
   logic [W-1:0]     s2_d;
   logic             s2_err;
   logic [TAG_W-1:0] s2_tag;

   // Whole pipeline advances together; an empty output stage never stalls.
   assign en          = !s2_valid | io.out_ready;
   assign io.in_ready = en;
   assign in_err      = (io.in_a >= Q_W) | (io.in_b >= Q_W);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_d     <= '0;
         s1_err   <= 1'b0;
         s1_tag   <= '0;
         s2_valid <= 1'b0;
         s2_d     <= '0;
         s2_err   <= 1'b0;
         s2_tag   <= '0;
      end else if (en) begin
         s1_valid <= io.in_valid;
         s1_d     <= {1'b0, io.in_a} - {1'b0, io.in_b};
         s1_err   <= in_err;
         s1_tag   <= io.in_tag;
         s2_valid <= s1_valid;
         // Borrow out of the 17-bit difference means A < B: fold back by Q.
         s2_d     <= s1_d[W] ? (s1_d[W-1:0] + Q_W) : s1_d[W-1:0];
         s2_err   <= s1_err;
         s2_tag   <= s1_tag;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count <= 8'd0;
      end else if (io.in_valid && en && in_err && (err_count != 8'hFF)) begin
         err_count <= err_count + 8'd1;
      end
   end

   assign io.out_valid = s2_valid;
   assign io.out_d     = s2_d;
   assign io.out_tag   = s2_tag;
   assign io.out_err   = s2_err;
   assign busy         = s1_valid | s2_valid;

endmodule

`default_nettype wire

// File: tb/tb_mod_sub_stream.sv
// ---------------------------------------------------------------------------
// tb_mod_sub_stream : scoreboard bench for mod_sub_stream
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mod_sub_stream;
   logic       clk = 1'b0;
   logic       rst;
   logic       busy;
   logic [7:0] err_count;

   mod_sub_stream_if #(.W(16), .TAG_W(8)) bus ();

   mod_sub_stream #(.Q(3329), .W(16), .TAG_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .io        (bus),
      .busy      (busy),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] d;
      logic [7:0]  tag;
      logic        err;
      int          acc;
      bit          chk_lat;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
      int r;
      r = int'(a) - int'(b);
      if (r < 0) r += 3329;
      return r[15:0];
   endfunction

   // Presents one pair and holds it until accepted; expected result is queued on acceptance.
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [7:0] tag,
                       input logic [15:0] exp_d, input logic exp_err, input bit lat,
                       output int acc);
      bit   done = 0;
      exp_t e;
      acc          = -1;
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_tag   = tag;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            @(posedge clk);
            #1;
            acc       = cyc;
            e.d       = exp_d;
            e.tag     = tag;
            e.err     = exp_err;
            e.acc     = cyc;
            e.chk_lat = lat;
            sb.push_back(e);
            done = 1;
         end
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout tag=%0d: got in_ready=0 expected 1", tag);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending results expected 0", sb.size());
         sb.delete();
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops and compares on every output transfer, and polices stalls.
   exp_t        m_e;
   logic        pstall = 1'b0;
   logic [15:0] pd;
   logic [7:0]  ptag;
   logic        perr;

   always @(negedge clk) begin
      if (rst) begin
         pstall = 1'b0;
      end else begin
         if (pstall) begin
            check("stall_hold", {7'd0, bus.out_valid, bus.out_d, bus.out_tag, bus.out_err},
                  {7'd0, 1'b1, pd, ptag, perr});
         end
         if (bus.out_valid && !bus.out_ready) begin
            check("stall_in_ready", bus.in_ready, 0);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_output: got d=%0d tag=%0d expected no output",
                        bus.out_d, bus.out_tag);
            end else begin
               m_e = sb.pop_front();
               check("result", {7'd0, bus.out_err, bus.out_tag, bus.out_d},
                     {7'd0, m_e.err, m_e.tag, m_e.d});
               if (m_e.chk_lat) check("latency", cyc, m_e.acc + 1);
            end
         end
         pstall = bus.out_valid && !bus.out_ready;
         pd     = bus.out_d;
         ptag   = bus.out_tag;
         perr   = bus.out_err;
      end
   end

   int  acc, acc1, acc2, rel;
   bit  rdone;
   logic [15:0] ra, rb;

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;
      #1;
      check("reset_out_valid", bus.out_valid, 0);
      check("reset_out_d", bus.out_d, 0);
      check("reset_out_tag", bus.out_tag, 0);
      check("reset_out_err", bus.out_err, 0);
      check("reset_busy", busy, 0);
      check("reset_in_ready", bus.in_ready, 1);
      check("reset_err_count", err_count, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic reduction, back to back
      send(16'd100,  16'd200,  8'd1, 16'd3229, 1'b0, 1, acc1);
      send(16'd3328, 16'd0,    8'd2, 16'd3328, 1'b0, 1, acc);
      send(16'd0,    16'd3328, 8'd3, 16'd1,    1'b0, 1, acc);
      send(16'd5,    16'd5,    8'd4, 16'd0,    1'b0, 1, acc2);
      check("basic_back_to_back", acc2 - acc1, 3);
      drain();
      check("basic_err_count", err_count, 0);

      // Backpressure mid-stream
      fork
         begin
            for (int i = 0; i < 6; i++)
               send(16'(50 + 10 * i), 16'(7 * i), 8'(10 + i), 16'(50 + 3 * i), 1'b0, 0, acc);
         end
         begin
            repeat (3) @(posedge clk);
            #1 bus.out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 bus.out_ready = 1'b1;
         end
      join
      drain();

      // Range errors and counter saturation
      send(16'd3329,  16'd0, 8'd20, 16'd3329,  1'b1, 0, acc);
      send(16'd65535, 16'd1, 8'd21, 16'd65534, 1'b1, 0, acc);
      drain();
      check("err_count_two", err_count, 2);
      for (int i = 0; i < 300; i++)
         send(16'(4000 + i), 16'd0, 8'(i), 16'(4000 + i), 1'b1, 0, acc);
      drain();
      check("err_count_sat", err_count, 255);
      send(16'd0, 16'd65535, 8'd99, 16'd3330, 1'b1, 0, acc);
      drain();
      check("err_count_hold", err_count, 255);

      // Random legal pairs with random output duty
      rdone = 0;
      fork
         begin
            for (int i = 0; i < 3000; i++) begin
               ra = 16'($urandom_range(0, 3328));
               rb = 16'($urandom_range(0, 3328));
               send(ra, rb, 8'(i), model(ra, rb), 1'b0, 0, acc);
            end
            rdone = 1;
         end
         begin
            while (!rdone) begin
               @(posedge clk);
               #1 bus.out_ready = ($urandom_range(0, 3) != 0);
            end
            bus.out_ready = 1'b1;
         end
      join
      drain();

      // Reset with both stages occupied
      bus.out_ready = 1'b0;
      send(16'd9,    16'd3, 8'd30, 16'd6,    1'b0, 0, acc);
      send(16'd4000, 16'd1, 8'd31, 16'd3999, 1'b1, 0, acc);
      check("full_busy", busy, 1);
      check("full_out_valid", bus.out_valid, 1);
      #1 rst = 1'b1;
      sb.delete();
      #1;
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_err_count", err_count, 0);
      check("midrst_in_ready", bus.in_ready, 1);
      @(posedge clk);
      #1 rst = 1'b0;
      bus.out_ready = 1'b1;
      send(16'd7, 16'd9, 8'd40, 16'd3327, 1'b0, 1, acc);
      @(negedge clk);
      check("postrst_not_early", bus.out_valid, 0);
      drain();

      // Bubble: empty output stage never blocks, then a held result stalls intake
      bus.out_ready = 1'b0;
      send(16'd20, 16'd10, 8'd50, 16'd10, 1'b0, 0, acc);
      repeat (2) @(posedge clk);
      #1;
      fork
         send(16'd30, 16'd40, 8'd51, 16'd3319, 1'b0, 0, acc2);
         begin
            repeat (4) @(posedge clk);
            #1 rel = cyc;
            bus.out_ready = 1'b1;
         end
      join
      check("bubble_accept_edge", acc2, rel + 1);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
